// File: rtl/rom_arbiter_pkg.sv
// Shared constants for the ROM arbiter: load funct3 encodings, response tag layout
// and the D-port fault rule.
package rom_arbiter_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        TAG_NONE  = 2'd0,
        TAG_I     = 2'd1,
        TAG_D_OK  = 2'd2,
        TAG_D_ERR = 2'd3
    } tag_kind_e;

    // Lane and size are only meaningful for TAG_D_OK.
    typedef struct packed {
        tag_kind_e  kind;
        logic [1:0] lane;
        logic [2:0] size;
    } tag_t;

    localparam tag_t TAG_RESET = '{kind: TAG_NONE, lane: 2'b00, size: 3'b000};

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_I    = 2'd1,
        GNT_D    = 2'd2
    } grant_e;

    function automatic logic load_fault(
        input logic [31:0] addr,
        input logic [2:0]  size,
        input logic [31:0] limit
    );
        logic fault;
        fault = (addr >= limit);
        case (size)
            F3_LB, F3_LBU: ;
            F3_LH, F3_LHU: if (addr[0]) fault = 1'b1;
            F3_LW:         if (addr[1:0] != 2'b00) fault = 1'b1;
            default:       fault = 1'b1;
        endcase
        return fault;
    endfunction

endpackage

// File: rtl/rom_arbiter_load_extend.sv
// Picks a byte/halfword/word out of a little-endian 32-bit word and sign- or
// zero-extends it according to the load funct3.
module rom_arbiter_load_extend
    import rom_arbiter_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        case (lane)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        // Halfword lanes are 0 or 2; lane[0] is excluded by the alignment check.
        half_sel = lane[1] ? word[31:16] : word[15:0];

        result = '0;
        case (funct3)
            F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  result = {24'h0, byte_sel};
            F3_LH:   result = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  result = {16'h0, half_sel};
            F3_LW:   result = word;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/rom_arbiter.sv
// Two-port arbiter in front of the synchronous-read instruction ROM: fetch (I) and
// rodata loads (D), one access per cycle, responses routed by a one-deep tag.
module rom_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter int SIZE         = 1024,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [2:0]  d_size,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] rom_addr,
    output logic [2:0]  rom_size,
    input  logic [31:0] rom_rd
);

    localparam int              CNT_W      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(STARVE_LIMIT);
    localparam logic [31:0]     ADDR_LIMIT = 32'(4 * SIZE);

    grant_e           grant;
    logic             d_fault;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    tag_t             tag_q, tag_d;
    logic [31:0]      rom_addr_q, rom_addr_d;
    logic [2:0]       rom_size_q, rom_size_d;
    logic [31:0]      ext_data;

    assign d_fault = load_fault(d_addr, d_size, ADDR_LIMIT);

    // D wins ties until it has been granted STARVE_LIMIT times in a row over a waiting I.
    always_comb begin
        grant = GNT_NONE;
        if (!rst) begin
            if (d_req && (!i_req || starve_cnt_q != CNT_MAX)) begin
                grant = GNT_D;
            end else if (i_req) begin
                grant = GNT_I;
            end
        end
    end

    assign i_gnt = (grant == GNT_I);
    assign d_gnt = (grant == GNT_D);

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!i_req || grant == GNT_I) begin
            starve_cnt_d = '0;
        end else if (grant == GNT_D && starve_cnt_q != CNT_MAX) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end

    // Faulting loads never reach the ROM, so the address/size keep their last value.
    always_comb begin
        tag_d      = TAG_RESET;
        rom_addr_d = rom_addr_q;
        rom_size_d = rom_size_q;
        case (grant)
            GNT_I: begin
                tag_d.kind = TAG_I;
                rom_addr_d = i_addr;
                rom_size_d = F3_LW;
            end
            GNT_D: begin
                if (d_fault) begin
                    tag_d.kind = TAG_D_ERR;
                end else begin
                    tag_d      = '{kind: TAG_D_OK, lane: d_addr[1:0], size: d_size};
                    rom_addr_d = d_addr;
                    rom_size_d = d_size;
                end
            end
            default: ;
        endcase
    end

    assign rom_addr = rom_addr_d;
    assign rom_size = rom_size_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_q <= '0;
            tag_q        <= TAG_RESET;
            rom_addr_q   <= '0;
            rom_size_q   <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            tag_q        <= tag_d;
            rom_addr_q   <= rom_addr_d;
            rom_size_q   <= rom_size_d;
        end
    end

    rom_arbiter_load_extend u_load_extend (
        .word   (rom_rd),
        .lane   (tag_q.lane),
        .funct3 (tag_q.size),
        .result (ext_data)
    );

    always_comb begin
        i_rvalid = (tag_q.kind == TAG_I);
        i_rdata  = i_rvalid ? rom_rd : 32'h0;
        d_rvalid = (tag_q.kind == TAG_D_OK) || (tag_q.kind == TAG_D_ERR);
        d_err    = (tag_q.kind == TAG_D_ERR);
        d_rdata  = (tag_q.kind == TAG_D_OK) ? ext_data : 32'h0;
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: directed vectors, starvation/back-to-back/reset
// sequences and a randomized run against a behavioural model.
module tb_rom_arbiter;

    localparam int SIZE  = 1024;
    localparam int LIMIT = 4;
    localparam int AW    = $clog2(SIZE);

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req;
    logic [31:0] i_addr, d_addr;
    logic [2:0]  d_size;
    logic        i_gnt, d_gnt, i_rvalid, d_rvalid, d_err;
    logic [31:0] i_rdata, d_rdata, rom_addr, rom_rd;
    logic [2:0]  rom_size;

    logic [31:0] rom_mem [SIZE];

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int          consec_d;
    logic        exp_i_v, exp_d_v, exp_d_e;
    logic [31:0] exp_i_data, exp_d_data;

    always #5 clk = ~clk;

    always @(posedge clk) rom_rd <= rom_mem[rom_addr[AW+1:2]];

    rom_arbiter #(.SIZE(SIZE), .STARVE_LIMIT(LIMIT)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_addr   (d_addr),
        .d_size   (d_size),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .d_err    (d_err),
        .rom_addr (rom_addr),
        .rom_size (rom_size),
        .rom_rd   (rom_rd)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic ref_fault(input logic [31:0] a, input logic [2:0] s);
        longint unsigned lim = 4 * SIZE;
        if (!(s == 0 || s == 1 || s == 2 || s == 4 || s == 5)) return 1'b1;
        if (longint'(a) >= lim) return 1'b1;
        if ((s == 1 || s == 5) && (a % 2) != 0) return 1'b1;
        if (s == 2 && (a % 4) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] s);
        logic [31:0] w = rom_mem[a / 4];
        int unsigned lane = a % 4;
        longint v;
        case (s)
            3'd0, 3'd4: begin
                v = longint'((w >> (8 * lane)) & 32'hFF);
                if (s == 0 && v >= 128) v = v - 256;
            end
            3'd1, 3'd5: begin
                v = longint'((w >> (8 * lane)) & 32'hFFFF);
                if (s == 1 && v >= 32768) v = v - 65536;
            end
            default: v = longint'(w);
        endcase
        return 32'(v);
    endfunction

    // Drive requests (called just after a rising edge), check grants mid-cycle and
    // load the expected response for the next cycle. exp_g: 0 none, 1 I, 2 D.
    task automatic drive_cycle(input logic ireq, input logic [31:0] ia, input logic dreq,
                               input logic [31:0] da, input logic [2:0] ds, output int exp_g);
        logic flt;
        i_req = ireq; i_addr = ia; d_req = dreq; d_addr = da; d_size = ds;
        @(negedge clk);
        if (ireq && dreq) exp_g = (consec_d >= LIMIT) ? 1 : 2;
        else if (dreq)    exp_g = 2;
        else if (ireq)    exp_g = 1;
        else              exp_g = 0;
        flt = ref_fault(da, ds);
        check("i_gnt", 32'(i_gnt), 32'(exp_g == 1));
        check("d_gnt", 32'(d_gnt), 32'(exp_g == 2));
        if (exp_g == 1) begin
            check("rom_addr_i", rom_addr, ia);
            check("rom_size_i", 32'(rom_size), 32'd2);
        end else if (exp_g == 2 && !flt) begin
            check("rom_addr_d", rom_addr, da);
            check("rom_size_d", 32'(rom_size), 32'(ds));
        end
        $display("t=%0t req i=%0b d=%0b i_addr=%h d_addr=%h size=%0d -> gnt i=%0b d=%0b",
                 $time, ireq, dreq, ia, da, ds, i_gnt, d_gnt);
        exp_i_v    = (exp_g == 1);
        exp_i_data = (exp_g == 1) ? rom_mem[ia / 4] : 32'h0;
        exp_d_v    = (exp_g == 2);
        exp_d_e    = (exp_g == 2) && flt;
        exp_d_data = (exp_g == 2 && !flt) ? ref_load(da, ds) : 32'h0;
        if (!ireq || exp_g == 1)           consec_d = 0;
        else if (exp_g == 2 && consec_d < LIMIT) consec_d++;
    endtask

    task automatic check_resp();
        check("i_rvalid", 32'(i_rvalid), 32'(exp_i_v));
        check("i_rdata",  i_rdata, exp_i_data);
        check("d_rvalid", 32'(d_rvalid), 32'(exp_d_v));
        check("d_err",    32'(d_err), 32'(exp_d_e));
        check("d_rdata",  d_rdata, exp_d_data);
    endtask

    task automatic cycle(input logic ireq, input logic [31:0] ia, input logic dreq,
                         input logic [31:0] da, input logic [2:0] ds, output int exp_g);
        drive_cycle(ireq, ia, dreq, da, ds, exp_g);
        @(posedge clk); #1;
        check_resp();
    endtask

    task automatic model_reset();
        consec_d = 0;
        exp_i_v = 1'b0; exp_d_v = 1'b0; exp_d_e = 1'b0;
        exp_i_data = '0; exp_d_data = '0;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    initial begin
        vec_t vecs[12];
        int   g;
        logic pi, pd;
        logic [31:0] ia, da;
        logic [2:0]  ds;

        for (int k = 0; k < SIZE; k++) rom_mem[k] = $urandom;
        rom_mem[2] = 32'h0050_0093;
        rom_mem[3] = 32'h1234_5678;
        rom_mem[4] = 32'h80FF_7F01;

        vecs[0]  = '{32'h11, 3'b000, 32'h0000_007F, 1'b0};
        vecs[1]  = '{32'h12, 3'b000, 32'hFFFF_FFFF, 1'b0};
        vecs[2]  = '{32'h13, 3'b100, 32'h0000_0080, 1'b0};
        vecs[3]  = '{32'h12, 3'b001, 32'hFFFF_80FF, 1'b0};
        vecs[4]  = '{32'h10, 3'b101, 32'h0000_7F01, 1'b0};
        vecs[5]  = '{32'h12, 3'b101, 32'h0000_80FF, 1'b0};
        vecs[6]  = '{32'h10, 3'b010, 32'h80FF_7F01, 1'b0};
        vecs[7]  = '{32'h10, 3'b001, 32'h0000_7F01, 1'b0};
        vecs[8]  = '{32'h06, 3'b010, 32'h0, 1'b1};
        vecs[9]  = '{32'h01, 3'b001, 32'h0, 1'b1};
        vecs[10] = '{32'h10, 3'b011, 32'h0, 1'b1};
        vecs[11] = '{32'(4 * SIZE), 3'b010, 32'h0, 1'b1};

        // Reset state with both requests asserted: no grants, no responses.
        rst = 1'b1; i_req = 1'b1; d_req = 1'b1; i_addr = 32'h8; d_addr = 32'h10; d_size = 3'b010;
        model_reset();
        @(posedge clk); #1;
        check("rst_i_gnt", 32'(i_gnt), 32'h0);
        check("rst_d_gnt", 32'(d_gnt), 32'h0);
        check("rst_rom_addr", rom_addr, 32'h0);
        check_resp();
        @(posedge clk); #1;
        rst = 1'b0;

        // Fetch only.
        cycle(1'b1, 32'h8, 1'b0, 32'h0, 3'b010, g);
        check("fetch_gnt", 32'(g), 32'd1);
        check("fetch_rvalid", 32'(i_rvalid), 32'h1);
        check("fetch_rdata", i_rdata, 32'h0050_0093);
        check("fetch_d_rvalid", 32'(d_rvalid), 32'h0);

        // Load extension and fault vectors.
        foreach (vecs[k]) begin
            cycle(1'b0, 32'h0, 1'b1, vecs[k].addr, vecs[k].size, g);
            check("vec_d_rvalid", 32'(d_rvalid), 32'h1);
            check("vec_d_err", 32'(d_err), 32'(vecs[k].exp_err));
            check("vec_d_rdata", d_rdata, vecs[k].exp_data);
            check("vec_i_rvalid", 32'(i_rvalid), 32'h0);
        end

        // Both requesting continuously: D D D D I repeating.
        for (int k = 0; k < 10; k++) begin
            cycle(1'b1, 32'h8, 1'b1, 32'h10, 3'b010, g);
            check("starve_pattern", 32'(g), (k % 5 == 4) ? 32'd1 : 32'd2);
        end
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 3'b010, g);

        // Back-to-back I, D, I with responses on consecutive cycles.
        cycle(1'b1, 32'hC, 1'b0, 32'h0, 3'b010, g);
        check("b2b_0_i", 32'(i_rvalid), 32'h1);
        cycle(1'b0, 32'h0, 1'b1, 32'h10, 3'b100, g);
        check("b2b_1_d", 32'(d_rvalid), 32'h1);
        check("b2b_1_data", d_rdata, 32'h0000_0001);
        cycle(1'b1, 32'h8, 1'b0, 32'h0, 3'b010, g);
        check("b2b_2_i", 32'(i_rvalid), 32'h1);
        check("b2b_2_data", i_rdata, 32'h0050_0093);

        // Build up the starvation count, then reset right after a D grant.
        for (int k = 0; k < 3; k++) cycle(1'b1, 32'h8, 1'b1, 32'h10, 3'b010, g);
        drive_cycle(1'b1, 32'h8, 1'b1, 32'h10, 3'b010, g);
        check("pre_rst_gnt", 32'(g), 32'd2);
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        #1;
        check("mid_rst_d_rvalid", 32'(d_rvalid), 32'h0);
        check("mid_rst_d_gnt", 32'(d_gnt), 32'h0);
        check("mid_rst_i_gnt", 32'(i_gnt), 32'h0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            check_resp();
        end
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, 32'h8, 1'b1, 32'h10, 3'b010, g);
            check("post_rst_pattern", 32'(g), (k == 4) ? 32'd1 : 32'd2);
        end
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 3'b010, g);

        // Randomized traffic; each request is held until the model says it was granted.
        pi = 1'b0; pd = 1'b0; ia = '0; da = '0; ds = '0;
        for (int n = 0; n < 600; n++) begin
            if (!pi && $urandom_range(0, 99) < 60) begin
                pi = 1'b1;
                ia = 32'($urandom_range(0, SIZE - 1)) * 4;
            end
            if (!pd && $urandom_range(0, 99) < 60) begin
                int r;
                pd = 1'b1;
                r = $urandom_range(0, 9);
                if (r == 0)      da = 32'(4 * SIZE) + 32'($urandom_range(0, 15));
                else if (r == 1) da = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                else             da = 32'($urandom_range(0, 4 * SIZE - 1));
                r = $urandom_range(0, 9);
                if (r == 0) begin
                    r = $urandom_range(0, 2);
                    ds = (r == 0) ? 3'b011 : ((r == 1) ? 3'b110 : 3'b111);
                end else begin
                    r = $urandom_range(0, 4);
                    ds = (r == 0) ? 3'b000 : (r == 1) ? 3'b001 : (r == 2) ? 3'b010 :
                         (r == 3) ? 3'b100 : 3'b101;
                end
            end
            cycle(pi, ia, pd, da, ds, g);
            if (g == 1) pi = 1'b0;
            if (g == 2) pd = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
